// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the multicycle MIPS controller
package mips_pkg;

    // Controller state encodings; 12-15 are unused and treated as illegal
    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXECUTE = 4'd6,
        ST_ALUWB   = 4'd7,
        ST_BEQ     = 4'd8,
        ST_ADDIEX  = 4'd9,
        ST_ADDIWB  = 4'd10,
        ST_JUMP    = 4'd11
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Coarse ALU request from the FSM; the decoder refines FUNCT via funct
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // ALU control codes driven to the datapath
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_aludec.sv
// rtl/multicycle_aludec.sv - aluop + funct to 3-bit ALU control decoder
import mips_pkg::*;

module multicycle_aludec (
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Unknown funct codes fall back to add so a bad R-type cannot select a surprise op
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FSM controller sequencing a shared-memory multicycle MIPS datapath
import mips_pkg::*;

module multicycle_ctrl #(
    parameter bit USE_MEMREADY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       memwrite,
    output logic       regwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    // Held as plain bits so that encodings 12-15 stay representable and recoverable
    logic [3:0] state_q;
    logic [3:0] state_d;

    logic       mem_done;
    logic       pcwrite;
    logic       branch;
    logic       irwrite_s;
    logic       memwrite_s;
    logic       regwrite_s;
    aluop_t     aluop;

    assign mem_done = USE_MEMREADY ? memready : 1'b1;

    // State register; reset returns to FETCH immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: memory-access states hold until the memory completes
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:   state_d = mem_done ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXECUTE;
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR:  state_d = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:   state_d = mem_done ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:   state_d = ST_FETCH;
            ST_MEMWR:   state_d = mem_done ? ST_FETCH : ST_MEMWR;
            ST_EXECUTE: state_d = ST_ALUWB;
            ST_ALUWB:   state_d = ST_FETCH;
            ST_BEQ:     state_d = ST_FETCH;
            ST_ADDIEX:  state_d = ST_ADDIWB;
            ST_ADDIWB:  state_d = ST_FETCH;
            ST_JUMP:    state_d = ST_FETCH;
            default:    state_d = ST_FETCH;
        endcase
    end

    // Per-state selects and raw enables; anything not named for a state stays 0
    always_comb begin
        iord       = 1'b0;
        irwrite_s  = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        case (state_q)
            ST_FETCH: begin
                alusrcb   = 2'b01;
                irwrite_s = mem_done;
                pcwrite   = mem_done;
            end
            ST_DECODE: begin
                alusrcb = 2'b11;
            end
            ST_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ST_MEMRD: begin
                iord = 1'b1;
            end
            ST_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            ST_MEMWR: begin
                iord       = 1'b1;
                memwrite_s = mem_done;
            end
            ST_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            ST_BEQ: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ST_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ST_ADDIWB: begin
                regwrite_s = 1'b1;
            end
            ST_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
                aluop = ALUOP_ADD;
            end
        endcase
    end

    // Write enables are suppressed while reset is held so no pulse escapes the reset cycle
    assign irwrite  = irwrite_s  & ~reset;
    assign memwrite = memwrite_s & ~reset;
    assign regwrite = regwrite_s & ~reset;
    assign pcen     = (pcwrite | (branch & zero)) & ~reset;
    assign state    = state_q;

    multicycle_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for the multicycle MIPS controller
module tb_multicycle_ctrl;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       iord, irwrite, pcen, memwrite, regwrite, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memready   (memready),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] alu_ref(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // What each step of an instruction does to the datapath, stated from the ISA view
    function automatic exp_t model(input int ph, input logic [5:0] f, input logic z, input logic mr);
        exp_t e;
        e            = '0;
        e.st         = 4'(ph);
        e.alucontrol = 3'b010;
        case (ph)
            0: begin e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
            1: e.alusrcb = 2'b11;
            2: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            3: e.iord = 1'b1;
            4: begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            5: begin e.iord = 1'b1; e.memwrite = mr; end
            6: begin e.alusrca = 1'b1; e.alucontrol = alu_ref(f); end
            7: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            8: begin e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
            9: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            10: e.regwrite = 1'b1;
            11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e         = model(0, 6'd0, 1'b0, 1'b1);
        e.irwrite = 1'b0;
        e.pcen    = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per clock, compared away from the active edge
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {state, iord, irwrite, pcen, memwrite, regwrite, memtoreg, regdst,
                 alusrca, alusrcb, pcsrc, alucontrol};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t state got=%0d expected=%0d vec got=%h expected=%h",
                         $time, a.st, e.st, a, e);
            end
        end
    end

    task automatic step(input int ph, input logic [5:0] o, input logic [5:0] f,
                        input logic mr, input logic z);
        op       = o;
        funct    = f;
        memready = mr;
        zero     = z;
        q.push_back(model(ph, f, z, mr));
        @(posedge clk);
        #1;
    endtask

    // Reference sequencing: the list of steps an instruction walks through
    task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input int sf,
                            input int sm, input logic zb);
        int p[$];
        int n;
        logic mr;
        p = {0, 1};
        case (o)
            T_LW:    p = {0, 1, 2, 3, 4};
            T_SW:    p = {0, 1, 2, 5};
            T_RTYPE: p = {0, 1, 6, 7};
            T_BEQ:   p = {0, 1, 8};
            T_ADDI:  p = {0, 1, 9, 10};
            T_J:     p = {0, 1, 11};
            default: p = {0, 1};
        endcase
        foreach (p[i]) begin
            n = (p[i] == 0) ? sf : ((p[i] == 3 || p[i] == 5) ? sm : 0);
            for (int c = 0; c <= n; c++) begin
                if (p[i] == 0 || p[i] == 3 || p[i] == 5) mr = (c == n);
                else mr = 1'($urandom_range(0, 1));
                step(p[i], o, f, mr, (p[i] == 8) ? zb : 1'($urandom_range(0, 1)));
            end
        end
    endtask

    logic [5:0] ops [8];
    logic [5:0] fns [6];

    initial begin
        ops = '{T_LW, T_SW, T_RTYPE, T_BEQ, T_ADDI, T_J, 6'b111111, 6'b000101};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

        reset    = 1'b1;
        op       = T_LW;
        funct    = 6'd0;
        zero     = 1'b0;
        memready = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(reset_exp());
        @(posedge clk);
        #1;
        reset = 1'b0;

        do_instr(T_LW, 6'd0, 0, 0, 1'b0);
        do_instr(T_RTYPE, 6'b101010, 0, 0, 1'b0);
        do_instr(T_BEQ, 6'd0, 0, 0, 1'b1);
        do_instr(T_BEQ, 6'd0, 0, 0, 1'b0);
        do_instr(T_SW, 6'd0, 0, 3, 1'b0);
        do_instr(T_ADDI, 6'd0, 2, 0, 1'b0);
        do_instr(T_J, 6'd0, 0, 0, 1'b0);

        // lw up to MEMWB, then reset lands mid-cycle
        step(0, T_LW, 6'd0, 1'b1, 1'b0);
        step(1, T_LW, 6'd0, 1'b1, 1'b0);
        step(2, T_LW, 6'd0, 1'b1, 1'b0);
        step(3, T_LW, 6'd0, 1'b1, 1'b0);
        op       = T_LW;
        memready = 1'b1;
        zero     = 1'b0;
        #1;
        check("memwb_state_before_reset", 32'(state), 32'd4);
        check("memwb_regwrite_before_reset", 32'(regwrite), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_regwrite", 32'(regwrite), 32'd0);
        check("async_reset_memtoreg", 32'(memtoreg), 32'd0);
        q.push_back(reset_exp());
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_instr(6'b111111, 6'd0, 0, 0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            logic [5:0] o;
            logic [5:0] f;
            o = ops[$urandom_range(0, 7)];
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            do_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
FSM controller that sequences a shared-memory multicycle MIPS datapath (fetch/decode/execute/memory/writeback) in place of the single-cycle decode.
It sits beside datapath. It takes op/funct/zero and drives all mux selects, write enables and the 3-bit ALU control.
A memory-ready handshake lets the unified instruction/data memory stall any memory-access state.

Parameters:
USE_MEMREADY, 1, if 0 the memready input is ignored and treated as constant 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
op  in  6  instr[31:26]
funct  in  6  instr[5:0]
zero  in  1  ALU zero flag from datapath
memready  in  1  memory completes the access this cycle
iord  out  1  memory address select: 0=PC, 1=ALUOut
irwrite  out  1  instruction register enable
pcen  out  1  PC enable = pcwrite | (branch & zero)
memwrite  out  1  memory write strobe
regwrite  out  1  register file write enable
memtoreg  out  1  writeback select: 1=Data register
regdst  out  1  destination select: 1=rd, 0=rt
alusrca  out  1  0=PC, 1=A register
alusrcb  out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
pcsrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
state  out  4  current state encoding, for debug and verification

Behaviour:
- Outputs are combinational from the registered state and inputs (Moore, except the memready qualification and pcen). State registers on posedge clk.
- reset asserted: state=FETCH immediately (async). Write enables forced 0: irwrite, pcen, memwrite, regwrite. Selects show FETCH values: iord=0, alusrca=0, alusrcb=01, pcsrc=00, alucontrol=010.
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12-15 are illegal and go to FETCH next cycle with all enables 0.
- FETCH: iord=0, alusrcb=01, aluop add. irwrite and pcwrite are asserted only when memready=1. Stays in FETCH while memready=0; goes to DECODE when memready=1.
- DECODE: alusrca=0, alusrcb=11, add (branch target to ALUOut). Next state by op:
  - 100011 lw or 101011 sw -> MEMADR
  - 000000 R-type -> EXECUTE
  - 000100 beq -> BEQ
  - 001000 addi -> ADDIEX
  - 000010 j -> JUMP
  - any other op -> FETCH (NOP, no writes)
- MEMADR: alusrca=1, alusrcb=10, add. Goes to MEMRD if op=lw, otherwise MEMWR.
- MEMRD: iord=1. Holds until memready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=memready. Holds until memready, then FETCH. memwrite is high for exactly one cycle.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct -> ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BEQ: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1 -> FETCH. pcen=zero.
- ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- ALU decode: aluop 00 -> 010; 01 -> 110; 10 -> by funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - any other funct -> 010
- Selects not listed for a state default to 0. Enables not listed default to 0.
- Latency with memready=1 throughout: lw 5 cycles; sw, R-type, addi 4; beq, j 3; unknown op 2.
- Reset mid-instruction: the instruction is abandoned and no enable pulses in the reset cycle.

Decomposition:
- Package mips_pkg holds:
  - state enum (4-bit) with the encodings above
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - aluop 2-bit type
  - ALU control constants
- Sub-module multicycle_aludec: combinational aluop + funct -> alucontrol. The FSM is the remainder.

Test Plan:
- Reset, then release with memready=1 and op=100011 (lw) -> state sequence 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. irwrite=1 only in cycle 1.
- R-type op=0, funct=101010, memready=1 -> in EXECUTE alucontrol=111. In ALUWB regdst=1 and regwrite=1. Total 4 cycles.
- beq with zero=1, then with zero=0 -> in BEQ, pcen=1 (zero=1) or pcen=0 (zero=0); pcsrc=01 and alucontrol=110 in both cases.
- sw with memready held 0 for 3 cycles in MEMWR -> state stays 5 for 4 cycles. memwrite=1 only in the final cycle. Then FETCH.
- FETCH with memready=0 for 2 cycles -> irwrite=0 and pcen=0 while stalled. The next memready=1 cycle gives one irwrite pulse.
- Assert reset asynchronously in MEMWB, plus an unknown op 111111 -> state=0 at once and regwrite=0. The unknown op goes DECODE->FETCH with no writes.
